// File: rtl/npu_pkg.sv
// Shared definitions for the NPU tile sequencer: widths, opcode encodings,
// end-of-program markers and the decoded control bundle.
package npu_pkg;

  localparam int IW = 20;
  localparam int AW = 6;

  localparam logic [1:0]  OP_PS   = 2'b00;
  localparam logic [1:0]  OP_SPK  = 2'b01;
  localparam logic [1:0]  OP_MAC  = 2'b10;
  localparam logic [11:0] END_DEC = 12'hFFF;
  localparam logic [7:0]  END_GAP = 8'hFF;

  typedef struct packed {
    logic [3:0] start_weight;
    logic [3:0] start_mac;
    logic       ps_en;
    logic       sum_en;
    logic [1:0] add_in_sel;
    logic [2:0] add_out_sel;
    logic       add_en;
    logic       consec_add_en;
    logic       router_bypass_en;
    logic       spike_buffer_en;
    logic       spike_en;
    logic       sum_or_local;
    logic       inject_en;
    logic [1:0] spike_in_sel;
    logic [1:0] spike_out_sel;
    logic       spike_bypass_en;
  } ctrl_t;

endpackage

// File: rtl/instr_mem_64x20.sv
// Behavioural 64x20 single-port instruction memory with active-low chip/write
// enables, synchronous output reset and a shutdown input that blanks Q.
module instr_mem_64x20
  import npu_pkg::*;
(
  input  logic          CLK,
  input  logic          CEB,
  input  logic          WEB,
  input  logic          RSTB,
  input  logic          SD,
  input  logic [AW-1:0] A,
  input  logic [IW-1:0] D,
  output logic [IW-1:0] Q
);

  logic [IW-1:0] r_mem [0:(1<<AW)-1];
  logic [IW-1:0] r_q;

  // Array contents survive reset; only the read latch is cleared.
  always_ff @(posedge CLK) begin
    if (!CEB && !WEB) r_mem[A] <= D;
  end

  always_ff @(posedge CLK) begin
    if (!RSTB)            r_q <= '0;
    else if (!CEB && WEB) r_q <= r_mem[A];
  end

  assign Q = SD ? '0 : r_q;

endmodule

// File: rtl/npu_seq_ctrl.sv
// NPU tile instruction sequencer: clock gate, instruction memory, gap-timed
// address stepping and registered decode of broadcast control fields.
module npu_seq_ctrl
  import npu_pkg::*;
(
  input  logic          clk,
  input  logic          rstb,
  input  logic [3:0]    subcore_sel,
  input  logic          start_instr_b,
  input  logic          read_or_write,
  input  logic [AW-1:0] addr_count,
  input  logic [IW-1:0] instr_in,
  output logic [3:0]    start_weight,
  output logic [3:0]    start_mac,
  output logic          ps_en,
  output logic          sum_en,
  output logic          add_en,
  output logic          consec_add_en,
  output logic          router_bypass_en,
  output logic [1:0]    add_in_sel,
  output logic [2:0]    add_out_sel,
  output logic          spike_buffer_en,
  output logic          spike_en,
  output logic          sum_or_local,
  output logic          inject_en,
  output logic          spike_bypass_en,
  output logic [1:0]    spike_in_sel,
  output logic [1:0]    spike_out_sel,
  output logic [AW-1:0] im_addr
);

  logic          w_en;
  logic          w_sd;
  logic          r_en_lat;
  logic          w_gclk;
  logic [AW-1:0] w_mem_addr;
  logic [IW-1:0] w_q;
  logic          r_start;
  logic          r_rw;
  logic [7:0]    r_cycle_gap;
  logic [AW-1:0] r_im_addr;
  ctrl_t         r_ctrl;

  function automatic ctrl_t decode_word(input ctrl_t cur, input logic [11:0] d);
    ctrl_t n;
    n = cur;
    if (d != END_DEC) begin
      case (d[11:10])
        OP_PS: begin
          n.ps_en            = d[9];
          n.sum_en           = d[8];
          n.add_in_sel       = d[7:6];
          n.add_out_sel      = d[5:3];
          n.add_en           = d[2];
          n.consec_add_en    = d[1];
          n.router_bypass_en = d[0];
        end
        OP_SPK: begin
          n.spike_buffer_en  = d[9];
          n.spike_en         = d[8];
          n.sum_or_local     = d[7];
          n.inject_en        = d[6];
          n.spike_in_sel     = d[5:4];
          n.spike_out_sel    = d[3:2];
          n.spike_bypass_en  = d[1];
        end
        OP_MAC: begin
          n.start_weight     = d[7:4];
          n.start_mac        = d[3:0];
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  // Enable is sampled while clk is low so gclk never produces a runt pulse.
  assign w_en = |subcore_sel;
  assign w_sd = ~w_en;

  always_latch begin
    if (!clk) r_en_lat <= w_en;
  end

  assign w_gclk     = clk & r_en_lat;
  assign w_mem_addr = r_im_addr | addr_count;

  instr_mem_64x20 u_mem (
    .CLK  (w_gclk),
    .CEB  (start_instr_b),
    .WEB  (read_or_write),
    .RSTB (rstb),
    .SD   (w_sd),
    .A    (w_mem_addr),
    .D    (instr_in),
    .Q    (w_q)
  );

  always_ff @(posedge w_gclk) begin
    if (!rstb) begin
      r_start <= 1'b0;
      r_rw    <= 1'b0;
    end else begin
      r_start <= start_instr_b;
      r_rw    <= read_or_write;
    end
  end

  // The gap field seen here belongs to the word read one edge earlier.
  always_ff @(posedge w_gclk) begin
    if (!rstb) begin
      r_cycle_gap <= '0;
      r_im_addr   <= '0;
    end else if (!r_start && r_rw) begin
      if (w_q[7:0] == END_GAP) begin
        r_cycle_gap <= '0;
        r_im_addr   <= '0;
      end else if (r_cycle_gap == w_q[7:0]) begin
        r_cycle_gap <= '0;
        r_im_addr   <= r_im_addr + 1'b1;
      end else begin
        r_cycle_gap <= r_cycle_gap + 1'b1;
      end
    end else begin
      r_cycle_gap <= '0;
      r_im_addr   <= '0;
    end
  end

  always_ff @(posedge w_gclk) begin
    if (!rstb) r_ctrl <= '0;
    else       r_ctrl <= decode_word(r_ctrl, w_q[19:8]);
  end

  assign start_weight     = r_ctrl.start_weight;
  assign start_mac        = r_ctrl.start_mac;
  assign ps_en            = r_ctrl.ps_en;
  assign sum_en           = r_ctrl.sum_en;
  assign add_en           = r_ctrl.add_en;
  assign consec_add_en    = r_ctrl.consec_add_en;
  assign router_bypass_en = r_ctrl.router_bypass_en;
  assign add_in_sel       = r_ctrl.add_in_sel;
  assign add_out_sel      = r_ctrl.add_out_sel;
  assign spike_buffer_en  = r_ctrl.spike_buffer_en;
  assign spike_en         = r_ctrl.spike_en;
  assign sum_or_local     = r_ctrl.sum_or_local;
  assign inject_en        = r_ctrl.inject_en;
  assign spike_bypass_en  = r_ctrl.spike_bypass_en;
  assign spike_in_sel     = r_ctrl.spike_in_sel;
  assign spike_out_sel    = r_ctrl.spike_out_sel;
  assign im_addr          = r_im_addr;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Directed bench for npu_seq_ctrl: decode vector table plus hand-traced
// sequences for gap timing, clock gating, mode exit and reset.
module tb_npu_seq_ctrl;

  logic        clk;
  logic        rstb;
  logic [3:0]  subcore_sel;
  logic        start_instr_b;
  logic        read_or_write;
  logic [5:0]  addr_count;
  logic [19:0] instr_in;
  logic [3:0]  start_weight, start_mac;
  logic        ps_en, sum_en, add_en, consec_add_en, router_bypass_en;
  logic [1:0]  add_in_sel;
  logic [2:0]  add_out_sel;
  logic        spike_buffer_en, spike_en, sum_or_local, inject_en, spike_bypass_en;
  logic [1:0]  spike_in_sel, spike_out_sel;
  logic [5:0]  im_addr;

  int n_checks = 0;
  int n_errors = 0;

  npu_seq_ctrl dut (
    .clk              (clk),
    .rstb             (rstb),
    .subcore_sel      (subcore_sel),
    .start_instr_b    (start_instr_b),
    .read_or_write    (read_or_write),
    .addr_count       (addr_count),
    .instr_in         (instr_in),
    .start_weight     (start_weight),
    .start_mac        (start_mac),
    .ps_en            (ps_en),
    .sum_en           (sum_en),
    .add_en           (add_en),
    .consec_add_en    (consec_add_en),
    .router_bypass_en (router_bypass_en),
    .add_in_sel       (add_in_sel),
    .add_out_sel      (add_out_sel),
    .spike_buffer_en  (spike_buffer_en),
    .spike_en         (spike_en),
    .sum_or_local     (sum_or_local),
    .inject_en        (inject_en),
    .spike_bypass_en  (spike_bypass_en),
    .spike_in_sel     (spike_in_sel),
    .spike_out_sel    (spike_out_sel),
    .im_addr          (im_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  sw;
    logic [3:0]  sm;
    logic        ps;
    logic        sum;
    logic [1:0]  ain;
    logic [2:0]  aout;
    logic        add;
    logic        cons;
    logic        rbyp;
    logic        sbuf;
    logic        spk;
    logic        sol;
    logic        inj;
    logic [1:0]  sin;
    logic [1:0]  sout;
    logic        sbyp;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] pack_exp(input vec_t v);
    return {5'd0, v.sw, v.sm, v.ps, v.sum, v.ain, v.aout, v.add, v.cons, v.rbyp,
            v.sbuf, v.spk, v.sol, v.inj, v.sin, v.sout, v.sbyp};
  endfunction

  function automatic logic [31:0] pack_act();
    return {5'd0, start_weight, start_mac, ps_en, sum_en, add_in_sel, add_out_sel,
            add_en, consec_add_en, router_bypass_en, spike_buffer_en, spike_en,
            sum_or_local, inject_en, spike_in_sel, spike_out_sel, spike_bypass_en};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_word(input logic [5:0] a, input logic [19:0] w);
    start_instr_b = 1'b0;
    read_or_write = 1'b0;
    addr_count    = a;
    instr_in      = w;
    tick();
  endtask

  task automatic set_exec();
    start_instr_b = 1'b0;
    read_or_write = 1'b1;
    addr_count    = 6'd0;
  endtask

  task automatic idle(input int n);
    start_instr_b = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  vec_t ex;
  logic [5:0] mac_im [10];
  logic [5:0] gap_im [5];

  initial begin
    // Cumulative expectations: unaddressed fields keep their previous values.
    vecs[0] = '{20'h853FF, 4'h5, 4'h3, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vecs[1] = '{20'h2D7FF, 4'h5, 4'h3, 1'b1, 1'b0, 2'd3, 3'd2, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vecs[2] = '{20'h440FF, 4'h5, 4'h3, 1'b1, 1'b0, 2'd3, 3'd2, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    vecs[3] = '{20'hC12FF, 4'h5, 4'h3, 1'b1, 1'b0, 2'd3, 3'd2, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    vecs[4] = '{20'h7B6FF, 4'h5, 4'h3, 1'b1, 1'b0, 2'd3, 3'd2, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd1, 1'b1};
    vecs[5] = '{20'hFFFFF, 4'h5, 4'h3, 1'b1, 1'b0, 2'd3, 3'd2, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd1, 1'b1};
    vecs[6] = '{20'h8A1FF, 4'hA, 4'h1, 1'b1, 1'b0, 2'd3, 3'd2, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd1, 1'b1};
    vecs[7] = '{20'h100FF, 4'hA, 4'h1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd1, 1'b1};

    mac_im = '{6'd0, 6'd1, 6'd2, 6'd0, 6'd0, 6'd1, 6'd2, 6'd0, 6'd0, 6'd1};
    gap_im = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd1};

    rstb          = 1'b0;
    subcore_sel   = 4'h1;
    start_instr_b = 1'b1;
    read_or_write = 1'b0;
    addr_count    = 6'd0;
    instr_in      = 20'd0;

    tick();
    tick();
    chk("reset_outputs", pack_act(), 32'd0);
    chk("reset_im_addr", {26'd0, im_addr}, 32'd0);
    rstb = 1'b1;

    // Each word ends with gap 0xFF so execution parks on address 0.
    for (int v = 0; v < 8; v++) begin
      load_word(6'd0, vecs[v].instr);
      set_exec();
      tick();
      tick();
      chk($sformatf("vec%0d_outputs", v), pack_act(), pack_exp(vecs[v]));
      chk($sformatf("vec%0d_im_addr", v), {26'd0, im_addr}, 32'd0);
    end

    idle(2);
    load_word(6'd0, 20'h85300);
    load_word(6'd1, 20'hFFFFF);
    load_word(6'd2, 20'hFFFFF);
    ex    = vecs[7];
    ex.sw = 4'h5;
    ex.sm = 4'h3;
    set_exec();
    for (int e = 0; e < 10; e++) begin
      if (e == 6) begin
        subcore_sel = 4'h0;
        tick();
        tick();
        tick();
        chk("gated_im_addr", {26'd0, im_addr}, 32'd1);
        chk("gated_outputs", pack_act(), pack_exp(ex));
        subcore_sel = 4'h1;
      end
      tick();
      chk($sformatf("mac_im_e%0d", e + 1), {26'd0, im_addr}, {26'd0, mac_im[e]});
      if (e >= 1) chk($sformatf("mac_out_e%0d", e + 1), pack_act(), pack_exp(ex));
    end

    // Sequencer keeps stepping for one edge, then clears.
    start_instr_b = 1'b1;
    tick();
    chk("exit_im_edge1", {26'd0, im_addr}, 32'd2);
    tick();
    chk("exit_im_edge2", {26'd0, im_addr}, 32'd0);
    chk("exit_outputs", pack_act(), pack_exp(ex));

    load_word(6'd0, 20'h44003);
    load_word(6'd1, 20'hFFFFF);
    ex.sbuf = 1'b0;
    ex.spk  = 1'b0;
    ex.sol  = 1'b0;
    ex.inj  = 1'b1;
    ex.sin  = 2'd0;
    ex.sout = 2'd0;
    ex.sbyp = 1'b0;
    set_exec();
    for (int e = 0; e < 5; e++) begin
      tick();
      chk($sformatf("gap_im_e%0d", e + 1), {26'd0, im_addr}, {26'd0, gap_im[e]});
      if (e == 1 || e == 4) chk($sformatf("gap_out_e%0d", e + 1), pack_act(), pack_exp(ex));
    end

    rstb = 1'b0;
    tick();
    chk("midrun_reset_outputs", pack_act(), 32'd0);
    chk("midrun_reset_im_addr", {26'd0, im_addr}, 32'd0);
    rstb = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
